// File: rtl/nmos_clk_pkg.sv
// rtl/nmos_clk_pkg.sv - shared state encoding and default timing for the NMOS two-phase clock generator
package nmos_clk_pkg;

   typedef enum logic [2:0] {
      ST_HALT = 3'd0,
      ST_P1   = 3'd1,
      ST_G1   = 3'd2,
      ST_P2   = 3'd3,
      ST_G2   = 3'd4
   } clk_state_e;

   localparam int DEF_PHI_CYC    = 3;
   localparam int DEF_GAP_CYC    = 1;
   localparam int DEF_RST_CYCLES = 4;
   localparam int DEF_CNT_W      = 32;

   function automatic int phi_period(input int phi_cyc, input int gap_cyc);
      return 2 * (phi_cyc + gap_cyc);
   endfunction

endpackage

// File: rtl/nmos_clk_gen.sv
// rtl/nmos_clk_gen.sv - two-phase non-overlapping PHI1/PHI2 generator with register reset sequencer
// Single-cycle stepping from HALT is enabled by defining NMOS_CLK_STEP_EN.
module nmos_clk_gen
   import nmos_clk_pkg::*;
#(
   parameter int PHI_CYC    = DEF_PHI_CYC,
   parameter int GAP_CYC    = DEF_GAP_CYC,
   parameter int RST_CYCLES = DEF_RST_CYCLES,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic             main_clk,
   input  logic             main_rst,
   input  logic             run,
   input  logic             step,
   output logic             phi1,
   output logic             phi2,
   output logic             nmos_rst,
   output logic             cyc_end,
   output logic             halted,
   output logic [CNT_W-1:0] cyc_cnt
);

   localparam int MAX_LD = (PHI_CYC > GAP_CYC) ? PHI_CYC : GAP_CYC;
   localparam int TMR_W  = (MAX_LD > 1) ? $clog2(MAX_LD) : 1;
   localparam logic [TMR_W-1:0] PHI_LD  = TMR_W'(PHI_CYC - 1);
   localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RST_CYCLES);

`ifdef NMOS_CLK_STEP_EN
   localparam logic STEP_EN = 1'b1;
`else
   localparam logic STEP_EN = 1'b0;
`endif

   if (PHI_CYC < 1) begin : g_bad_phi
      $error("nmos_clk_gen: PHI_CYC must be >= 1");
   end
   if (GAP_CYC < 1) begin : g_bad_gap
      $error("nmos_clk_gen: GAP_CYC must be >= 1");
   end

   clk_state_e       state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             phi1_q, phi1_d;
   logic             phi2_q, phi2_d;
   logic             nmos_rst_q, nmos_rst_d;
   logic             cyc_end_q, cyc_end_d;
   logic             halted_q, halted_d;
   logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;

   logic tmr_done;
   logic g2_last;
   logic start;

   always_comb begin
      tmr_done = (tmr_q == '0);
      g2_last  = (state_q == ST_G2) && tmr_done;
      start    = run | (step & STEP_EN);

      state_d = state_q;
      tmr_d   = tmr_done ? tmr_q : tmr_q - 1'b1;

      case (state_q)
         ST_HALT: begin
            tmr_d = '0;
            if (start) begin
               state_d = ST_P1;
               tmr_d   = PHI_LD;
            end
         end
         ST_P1: if (tmr_done) begin
            state_d = ST_G1;
            tmr_d   = GAP_LD;
         end
         ST_G1: if (tmr_done) begin
            state_d = ST_P2;
            tmr_d   = PHI_LD;
         end
         ST_P2: if (tmr_done) begin
            state_d = ST_G2;
            tmr_d   = GAP_LD;
         end
         ST_G2: if (tmr_done) begin
            state_d = run ? ST_P1 : ST_HALT;
            tmr_d   = run ? PHI_LD : '0;
         end
         default: begin
            state_d = ST_HALT;
            tmr_d   = '0;
         end
      endcase

      // Outputs trail the state by one edge so every output is a plain flop.
      phi1_d     = (state_q == ST_P1);
      phi2_d     = (state_q == ST_P2);
      halted_d   = (state_q == ST_HALT);
      cyc_end_d  = g2_last;
      cyc_cnt_d  = cyc_cnt_q + CNT_W'(g2_last);
      nmos_rst_d = nmos_rst_q & (cyc_cnt_d != RST_CNT);
   end

   always_ff @(posedge main_clk) begin
      if (main_rst) begin
         state_q    <= ST_HALT;
         tmr_q      <= '0;
         phi1_q     <= 1'b0;
         phi2_q     <= 1'b0;
         nmos_rst_q <= 1'b1;
         cyc_end_q  <= 1'b0;
         halted_q   <= 1'b1;
         cyc_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         phi1_q     <= phi1_d;
         phi2_q     <= phi2_d;
         nmos_rst_q <= nmos_rst_d;
         cyc_end_q  <= cyc_end_d;
         halted_q   <= halted_d;
         cyc_cnt_q  <= cyc_cnt_d;
      end
   end

   assign phi1     = phi1_q;
   assign phi2     = phi2_q;
   assign nmos_rst = nmos_rst_q;
   assign cyc_end  = cyc_end_q;
   assign halted   = halted_q;
   assign cyc_cnt  = cyc_cnt_q;

endmodule

// File: tb/tb_nmos_clk_gen.sv
// tb/tb_nmos_clk_gen.sv - randomized and directed checks of nmos_clk_gen against a position-in-period model
module tb_nmos_clk_gen;
   import nmos_clk_pkg::*;

   localparam int PHI = DEF_PHI_CYC;
   localparam int GAP = DEF_GAP_CYC;
   localparam int RSTC = DEF_RST_CYCLES;
   localparam int CW = DEF_CNT_W;
   localparam int PER = 2 * (PHI + GAP);

`ifdef NMOS_CLK_STEP_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic          main_clk = 1'b0;
   logic          main_rst;
   logic          run;
   logic          step;
   logic          phi1, phi2, nmos_rst, cyc_end, halted;
   logic [CW-1:0] cyc_cnt;

   nmos_clk_gen #(
      .PHI_CYC(PHI), .GAP_CYC(GAP), .RST_CYCLES(RSTC), .CNT_W(CW)
   ) dut (
      .main_clk(main_clk), .main_rst(main_rst), .run(run), .step(step),
      .phi1(phi1), .phi2(phi2), .nmos_rst(nmos_rst), .cyc_end(cyc_end),
      .halted(halted), .cyc_cnt(cyc_cnt)
   );

   always #5 main_clk = ~main_clk;

   int n_checks = 0;
   int n_fail = 0;

   // Model: position within the PHI period (-1 when idle); outputs after an edge reflect the position before it.
   int            m_pos = -1;
   logic [CW-1:0] m_cnt = '0;
   bit            m_clr = 1'b0;
   bit e_phi1, e_phi2, e_nrst, e_end, e_halt;
   int p1_len = 0;
   int p2_len = 0;
   int p1_rises = 0;
   int p2_rises = 0;
   bit prev_phi1 = 1'b0;
   bit prev_phi2 = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      bit rst_s, run_s, step_s, start;
      @(posedge main_clk);
      rst_s  = main_rst;
      run_s  = run;
      step_s = step;
      if (rst_s) begin
         e_phi1 = 0; e_phi2 = 0; e_end = 0; e_halt = 1; e_nrst = 1;
         m_pos = -1; m_cnt = '0; m_clr = 0;
      end else begin
         e_phi1 = (m_pos >= 0) && (m_pos < PHI);
         e_phi2 = (m_pos >= PHI + GAP) && (m_pos < 2 * PHI + GAP);
         e_halt = (m_pos < 0);
         e_end  = (m_pos == PER - 1);
         if (e_end) m_cnt = m_cnt + 1'b1;
         if (m_cnt == CW'(RSTC)) m_clr = 1;
         e_nrst = !m_clr;
         start = run_s || (STEP_EN && step_s);
         if (m_pos < 0) m_pos = start ? 0 : -1;
         else if (m_pos == PER - 1) m_pos = run_s ? 0 : -1;
         else m_pos = m_pos + 1;
      end
      #1;
      check_val("phi1", phi1, e_phi1);
      check_val("phi2", phi2, e_phi2);
      check_val("nmos_rst", nmos_rst, e_nrst);
      check_val("cyc_end", cyc_end, e_end);
      check_val("halted", halted, e_halt);
      check_val("cyc_cnt", cyc_cnt, m_cnt);
      check_val("no_overlap", phi1 & phi2, 0);
      if (phi1 && !prev_phi1) p1_rises++;
      if (phi2 && !prev_phi2) p2_rises++;
      prev_phi1 = phi1;
      prev_phi2 = phi2;
      if (rst_s) begin
         p1_len = 0;
         p2_len = 0;
      end else begin
         if (phi1) p1_len++;
         else if (p1_len > 0) begin
            check_val("phi1_width", p1_len, PHI);
            p1_len = 0;
         end
         if (phi2) p2_len++;
         else if (p2_len > 0) begin
            check_val("phi2_width", p2_len, PHI);
            p2_len = 0;
         end
      end
   endtask

   task automatic do_reset();
      main_rst = 1; run = 0; step = 0;
      tick();
      tick();
      main_rst = 0;
   endtask

   initial begin
      main_rst = 1; run = 0; step = 0;

      // Reset values and the basic waveform; edge e is the e-th edge with run sampled high.
      do_reset();
      check_val("rst_halted", halted, 1);
      check_val("rst_nmos_rst", nmos_rst, 1);
      check_val("rst_cyc_cnt", cyc_cnt, 0);
      for (int e = 1; e <= 34; e++) begin
         run = 1;
         tick();
         if (e == 1) check_val("halted_e1", halted, 1);
         if (e == 2) check_val("halted_e2", halted, 0);
         if (e >= 2 && e <= 4) check_val("phi1_e2_4", phi1, 1);
         if (e == 5) check_val("phi1_e5", phi1, 0);
         if (e >= 6 && e <= 8) check_val("phi2_e6_8", phi2, 1);
         if (e == 9) check_val("cyc_end_e9", cyc_end, 1);
         if (e == 10) check_val("phi1_e10", phi1, 1);
         if (e == 32) check_val("nmos_rst_e32", nmos_rst, 1);
         if (e == 33) begin
            check_val("nmos_rst_e33", nmos_rst, 0);
            check_val("cyc_cnt_e33", cyc_cnt, 4);
         end
      end

      // Drop run during P2 of cycle 3: run sampled low from edge 22 on.
      do_reset();
      for (int e = 1; e <= 40; e++) begin
         run = (e <= 21);
         tick();
         if (e == 25) check_val("stop_cyc_end", cyc_end, 1);
         if (e == 26) begin
            check_val("stop_halted", halted, 1);
            check_val("stop_cyc_cnt", cyc_cnt, 3);
            p1_rises = 0;
            p2_rises = 0;
         end
      end
      check_val("stop_no_phi1", p1_rises, 0);
      check_val("stop_no_phi2", p2_rises, 0);

      // Reset asserted while phi1 is high in cycle 2.
      do_reset();
      for (int e = 1; e <= 11; e++) begin
         run = 1;
         main_rst = (e == 11);
         tick();
         if (e == 10) check_val("pre_rst_phi1", phi1, 1);
      end
      check_val("midrst_phi1", phi1, 0);
      check_val("midrst_phi2", phi2, 0);
      check_val("midrst_nmos_rst", nmos_rst, 1);
      check_val("midrst_cyc_cnt", cyc_cnt, 0);
      main_rst = 0;

      // Single step pulse with run low.
      do_reset();
      run = 0;
      step = 1;
      tick();
      step = 0;
      p1_rises = 0;
      p2_rises = 0;
      for (int i = 0; i < 3 * PER; i++) tick();
      check_val("step_phi1_pulses", p1_rises, STEP_EN ? 1 : 0);
      check_val("step_phi2_pulses", p2_rises, STEP_EN ? 1 : 0);
      check_val("step_cyc_cnt", cyc_cnt, STEP_EN ? 1 : 0);
      check_val("step_halted", halted, 1);

      // Random run/step/reset toggling.
      do_reset();
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 15) == 0) run = ~run;
         step = ($urandom_range(0, 19) == 0);
         main_rst = ($urandom_range(0, 299) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
